// File: rtl/ram1_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : ram1_ctrl
//  Purpose  : MEM-stage load/store to RAM1 ce/re/we bus initiator with
//             registered RAM-side signals and a programmable wait count.
//             Optional byte-lane read-modify-write: define RAM1_BYTE_WRITE_EN.
//  Revision : 1.0 - initial release
// ============================================================================
module ram1_ctrl #(
    parameter int WAIT_CYCLES = 2,
    parameter int ADDR_SHIFT  = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_req_i,
    input  logic        cpu_we_i,
    input  logic [31:0] cpu_addr_i,
    input  logic [31:0] cpu_data_i,
    input  logic [3:0]  cpu_sel_i,
    output logic [31:0] cpu_data_o,
    output logic        cpu_ack_o,
    output logic        stall_req_o,
    output logic [31:0] mem_data_o,
    input  logic [31:0] mem_data_i,
    output logic [31:0] mem_addr_o,
    output logic        mem_ce_o,
    output logic        mem_re_o,
    output logic        mem_we_o
);

    localparam int         c_WAIT     = (WAIT_CYCLES < 1) ? 1 : WAIT_CYCLES;
    localparam logic [3:0] c_CNT_LOAD = 4'(c_WAIT - 1);

`ifdef RAM1_BYTE_WRITE_EN
    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_READ      = 3'd1,
        S_WRITE     = 3'd2,
        S_DONE      = 3'd3,
        S_RMW_READ  = 3'd4,
        S_RMW_WRITE = 3'd5
    } state_t;
`else
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_WRITE = 2'd2,
        S_DONE  = 2'd3
    } state_t;
`endif

    state_t      r_state;
    logic [3:0]  r_count;
    logic        w_busy;

`ifdef RAM1_BYTE_WRITE_EN
    logic [3:0]  r_sel;
    logic [31:0] w_merge;

    // mem_data_o still holds the store data latched at acceptance
    always_comb begin
        w_merge = mem_data_i;
        for (int i = 0; i < 4; i++) begin
            if (r_sel[i]) w_merge[8*i +: 8] = mem_data_o[8*i +: 8];
        end
    end

    assign w_busy = (r_state == S_READ) || (r_state == S_WRITE) ||
                    (r_state == S_RMW_READ) || (r_state == S_RMW_WRITE);
`else
    logic w_unused_sel;
    assign w_unused_sel = ^cpu_sel_i;
    assign w_busy       = (r_state == S_READ) || (r_state == S_WRITE);
`endif

    assign stall_req_o = ((r_state == S_IDLE) && cpu_req_i) || w_busy;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_count    <= 4'd0;
            mem_ce_o   <= 1'b0;
            mem_re_o   <= 1'b0;
            mem_we_o   <= 1'b0;
            mem_addr_o <= 32'd0;
            mem_data_o <= 32'd0;
            cpu_data_o <= 32'd0;
            cpu_ack_o  <= 1'b0;
`ifdef RAM1_BYTE_WRITE_EN
            r_sel      <= 4'd0;
`endif
        end else begin
            cpu_ack_o <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (cpu_req_i) begin
                        mem_addr_o <= cpu_addr_i >> ADDR_SHIFT;
                        mem_data_o <= cpu_data_i;
                        r_count    <= c_CNT_LOAD;
                        mem_ce_o   <= 1'b1;
                        if (!cpu_we_i) begin
                            mem_re_o <= 1'b1;
                            r_state  <= S_READ;
                        end else begin
`ifdef RAM1_BYTE_WRITE_EN
                            if (cpu_sel_i != 4'b1111) begin
                                r_sel    <= cpu_sel_i;
                                mem_re_o <= 1'b1;
                                r_state  <= S_RMW_READ;
                            end else begin
                                mem_we_o <= 1'b1;
                                r_state  <= S_WRITE;
                            end
`else
                            mem_we_o <= 1'b1;
                            r_state  <= S_WRITE;
`endif
                        end
                    end
                end
                S_READ: begin
                    if (r_count == 4'd0) begin
                        cpu_data_o <= mem_data_i;
                        mem_ce_o   <= 1'b0;
                        mem_re_o   <= 1'b0;
                        cpu_ack_o  <= 1'b1;
                        r_state    <= S_DONE;
                    end else begin
                        r_count <= r_count - 4'd1;
                    end
                end
                S_WRITE: begin
                    if (r_count == 4'd0) begin
                        mem_ce_o  <= 1'b0;
                        mem_we_o  <= 1'b0;
                        cpu_ack_o <= 1'b1;
                        r_state   <= S_DONE;
                    end else begin
                        r_count <= r_count - 4'd1;
                    end
                end
`ifdef RAM1_BYTE_WRITE_EN
                S_RMW_READ: begin
                    if (r_count == 4'd0) begin
                        mem_data_o <= w_merge;
                        mem_re_o   <= 1'b0;
                        mem_we_o   <= 1'b1;
                        r_count    <= c_CNT_LOAD;
                        r_state    <= S_RMW_WRITE;
                    end else begin
                        r_count <= r_count - 4'd1;
                    end
                end
                S_RMW_WRITE: begin
                    if (r_count == 4'd0) begin
                        mem_ce_o  <= 1'b0;
                        mem_we_o  <= 1'b0;
                        cpu_ack_o <= 1'b1;
                        r_state   <= S_DONE;
                    end else begin
                        r_count <= r_count - 4'd1;
                    end
                end
`endif
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    mem_ce_o <= 1'b0;
                    mem_re_o <= 1'b0;
                    mem_we_o <= 1'b0;
                    r_state  <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ram1_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ram1_ctrl
//  Purpose  : Directed self-checking bench for ram1_ctrl (WAIT_CYCLES = 2)
//             with a combinational-read RAM model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ram1_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_req_i;
    logic        cpu_we_i;
    logic [31:0] cpu_addr_i;
    logic [31:0] cpu_data_i;
    logic [3:0]  cpu_sel_i;
    logic [31:0] cpu_data_o;
    logic        cpu_ack_o;
    logic        stall_req_o;
    logic [31:0] mem_data_o;
    logic [31:0] mem_data_i;
    logic [31:0] mem_addr_o;
    logic        mem_ce_o;
    logic        mem_re_o;
    logic        mem_we_o;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [31:0] ram [0:255];

    ram1_ctrl #(.WAIT_CYCLES(2), .ADDR_SHIFT(2)) dut (
        .clk         (clk),
        .rst         (rst),
        .cpu_req_i   (cpu_req_i),
        .cpu_we_i    (cpu_we_i),
        .cpu_addr_i  (cpu_addr_i),
        .cpu_data_i  (cpu_data_i),
        .cpu_sel_i   (cpu_sel_i),
        .cpu_data_o  (cpu_data_o),
        .cpu_ack_o   (cpu_ack_o),
        .stall_req_o (stall_req_o),
        .mem_data_o  (mem_data_o),
        .mem_data_i  (mem_data_i),
        .mem_addr_o  (mem_addr_o),
        .mem_ce_o    (mem_ce_o),
        .mem_re_o    (mem_re_o),
        .mem_we_o    (mem_we_o)
    );

    always #5 clk = ~clk;

    assign mem_data_i = ram[mem_addr_o[7:0]];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mem_ce_o && mem_we_o) ram[mem_addr_o[7:0]] <= mem_data_o;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Issue a load and wait (bounded) for its ack; leaves req low afterwards.
    task automatic do_read(input logic [31:0] addr, output logic [31:0] data, output bit got_ack);
        got_ack    = 1'b0;
        cpu_req_i  = 1'b1;
        cpu_we_i   = 1'b0;
        cpu_addr_i = addr;
        for (int i = 0; i < 10 && !got_ack; i++) begin
            tick();
            if (cpu_ack_o) got_ack = 1'b1;
        end
        data      = cpu_data_o;
        cpu_req_i = 1'b0;
        tick();
    endtask

    task automatic test_reset;
        int ack_seen;
        checks++;
        if ({mem_ce_o, mem_re_o, mem_we_o, cpu_ack_o} !== 4'b0 || mem_addr_o !== 32'd0 ||
            mem_data_o !== 32'd0 || cpu_data_o !== 32'd0) begin
            errors++;
            $display("FAIL reset_state: ce/re/we/ack=%b addr=%h wdata=%h rdata=%h, required all zero",
                     {mem_ce_o, mem_re_o, mem_we_o, cpu_ack_o}, mem_addr_o, mem_data_o, cpu_data_o);
        end
        tick();
        rst = 1'b0;
        tick();
        checks++;
        if (stall_req_o !== 1'b0) begin
            errors++;
            $display("FAIL idle_stall: stall=%b required 0", stall_req_o);
        end
        // Start a read, then reset in the middle of it
        cpu_req_i  = 1'b1;
        cpu_we_i   = 1'b0;
        cpu_addr_i = 32'h40;
        tick();
        checks++;
        if ({mem_ce_o, mem_re_o} !== 2'b11) begin
            errors++;
            $display("FAIL reset_preread: ce/re=%b required 11", {mem_ce_o, mem_re_o});
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({mem_ce_o, mem_re_o, mem_we_o} !== 3'b000) begin
            errors++;
            $display("FAIL reset_async: ce/re/we=%b required 000", {mem_ce_o, mem_re_o, mem_we_o});
        end
        tick();
        rst       = 1'b0;
        cpu_req_i = 1'b0;
        ack_seen  = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (cpu_ack_o) ack_seen++;
        end
        checks++;
        if (ack_seen != 0 || mem_ce_o !== 1'b0 || mem_addr_o !== 32'd0 || cpu_data_o !== 32'd0) begin
            errors++;
            $display("FAIL reset_drop: acks=%0d ce=%b addr=%h rdata=%h, required 0/0/0/0",
                     ack_seen, mem_ce_o, mem_addr_o, cpu_data_o);
        end
    endtask

    task automatic test_read;
        ram[8'h10] = 32'hDEADBEEF;
        cpu_req_i  = 1'b1;
        cpu_we_i   = 1'b0;
        cpu_addr_i = 32'h40;
        cpu_data_i = 32'h0;
        #1;
        checks++;
        if (stall_req_o !== 1'b1) begin
            errors++;
            $display("FAIL read_stall_n: stall=%b required 1", stall_req_o);
        end
        tick();
        checks++;
        if (mem_addr_o !== 32'h10 || {mem_ce_o, mem_re_o, mem_we_o, stall_req_o, cpu_ack_o} !== 5'b11010) begin
            errors++;
            $display("FAIL read_n1: addr=%h ce/re/we/stall/ack=%b, required 00000010 11010",
                     mem_addr_o, {mem_ce_o, mem_re_o, mem_we_o, stall_req_o, cpu_ack_o});
        end
        tick();
        checks++;
        if ({mem_ce_o, mem_re_o, mem_we_o, stall_req_o, cpu_ack_o} !== 5'b11010) begin
            errors++;
            $display("FAIL read_n2: ce/re/we/stall/ack=%b required 11010",
                     {mem_ce_o, mem_re_o, mem_we_o, stall_req_o, cpu_ack_o});
        end
        tick();
        checks++;
        if (cpu_ack_o !== 1'b1 || cpu_data_o !== 32'hDEADBEEF || stall_req_o !== 1'b0 || mem_ce_o !== 1'b0) begin
            errors++;
            $display("FAIL read_ack: ack=%b data=%h stall=%b ce=%b, required 1 DEADBEEF 0 0",
                     cpu_ack_o, cpu_data_o, stall_req_o, mem_ce_o);
        end
        cpu_req_i = 1'b0;
        tick();
        checks++;
        if (cpu_ack_o !== 1'b0 || cpu_data_o !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL read_hold: ack=%b data=%h, required 0 DEADBEEF", cpu_ack_o, cpu_data_o);
        end
    endtask

    task automatic test_write;
        int          nwe;
        bit          re_seen, bad_addr, done;
        logic [31:0] rd;
        bit          got;
        nwe = 0; re_seen = 0; bad_addr = 0; done = 0;
        ram[8'h11] = 32'h0;
        cpu_req_i  = 1'b1;
        cpu_we_i   = 1'b1;
        cpu_addr_i = 32'h44;
        cpu_data_i = 32'h12345678;
        cpu_sel_i  = 4'b1111;
        for (int i = 0; i < 12 && !done; i++) begin
            tick();
            if (mem_we_o) begin
                nwe++;
                if (mem_addr_o !== 32'h11 || mem_data_o !== 32'h12345678) bad_addr = 1;
            end
            if (mem_re_o) re_seen = 1;
            if (cpu_ack_o) done = 1;
        end
        cpu_req_i = 1'b0;
        cpu_we_i  = 1'b0;
        checks++;
        if (!done || nwe != 2 || re_seen || bad_addr) begin
            errors++;
            $display("FAIL write_cycle: ack=%0d we_cycles=%0d re_seen=%0d bad_addr=%0d, required 1 2 0 0",
                     done, nwe, re_seen, bad_addr);
        end
        checks++;
        if (cpu_data_o !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL write_keeps_rdata: data=%h required DEADBEEF", cpu_data_o);
        end
        tick();
        checks++;
        if (cpu_ack_o !== 1'b0 || ram[8'h11] !== 32'h12345678) begin
            errors++;
            $display("FAIL write_mem: ack=%b ram[11]=%h, required 0 12345678", cpu_ack_o, ram[8'h11]);
        end
        do_read(32'h44, rd, got);
        checks++;
        if (!got || rd !== 32'h12345678) begin
            errors++;
            $display("FAIL write_readback: ack=%0d data=%h, required 1 12345678", got, rd);
        end
    endtask

    task automatic test_back_to_back;
        int t1, t2;
        bit done;
        ram[8'h12] = 32'hCAFEF00D;
        t1 = -100; t2 = 0; done = 0;
        cpu_req_i  = 1'b1;
        cpu_we_i   = 1'b0;
        cpu_addr_i = 32'h40;
        for (int i = 0; i < 10 && !done; i++) begin
            tick();
            if (cpu_ack_o) begin done = 1; t1 = cyc; end
        end
        cpu_addr_i = 32'h48;
        tick();
        checks++;
        if (mem_ce_o !== 1'b0 || stall_req_o !== 1'b1 || cpu_ack_o !== 1'b0) begin
            errors++;
            $display("FAIL b2b_gap: ce=%b stall=%b ack=%b, required 0 1 0", mem_ce_o, stall_req_o, cpu_ack_o);
        end
        tick();
        checks++;
        if (mem_ce_o !== 1'b1 || mem_re_o !== 1'b1 || mem_addr_o !== 32'h12) begin
            errors++;
            $display("FAIL b2b_second: ce=%b re=%b addr=%h, required 1 1 00000012", mem_ce_o, mem_re_o, mem_addr_o);
        end
        done = 0;
        for (int i = 0; i < 10 && !done; i++) begin
            if (cpu_ack_o) begin done = 1; t2 = cyc; end
            else tick();
        end
        checks++;
        if (!done || (t2 - t1) != 4 || cpu_data_o !== 32'hCAFEF00D) begin
            errors++;
            $display("FAIL b2b_latency: ack=%0d spacing=%0d data=%h, required 1 4 CAFEF00D",
                     done, t2 - t1, cpu_data_o);
        end
        cpu_req_i = 1'b0;
        tick();
    endtask

    task automatic test_latched;
        bit done, moved;
        ram[8'h20] = 32'h0BADCAFE;
        done = 0; moved = 0;
        cpu_req_i  = 1'b1;
        cpu_we_i   = 1'b0;
        cpu_addr_i = 32'h40;
        tick();
        cpu_addr_i = 32'h80;
        cpu_we_i   = 1'b1;
        cpu_data_i = 32'hFFFFFFFF;
        cpu_req_i  = 1'b0;
        for (int i = 0; i < 10 && !done; i++) begin
            if (mem_ce_o && (mem_addr_o !== 32'h10 || mem_we_o)) moved = 1;
            if (cpu_ack_o) done = 1;
            else tick();
        end
        checks++;
        if (!done || moved || cpu_data_o !== 32'hDEADBEEF || ram[8'h20] !== 32'h0BADCAFE) begin
            errors++;
            $display("FAIL latched_req: ack=%0d changed=%0d data=%h ram[20]=%h, required 1 0 DEADBEEF 0BADCAFE",
                     done, moved, cpu_data_o, ram[8'h20]);
        end
        cpu_we_i = 1'b0;
        tick();
        tick();
    endtask

`ifdef RAM1_BYTE_WRITE_EN
    task automatic test_rmw;
        int lat;
        bit done, overlap;
        ram[8'h11] = 32'hAABBCCDD;
        lat = 0; done = 0; overlap = 0;
        cpu_req_i  = 1'b1;
        cpu_we_i   = 1'b1;
        cpu_addr_i = 32'h44;
        cpu_data_i = 32'h00000099;
        cpu_sel_i  = 4'b0001;
        for (int i = 0; i < 12 && !done; i++) begin
            tick();
            lat++;
            if (mem_re_o && mem_we_o) overlap = 1;
            if (cpu_ack_o) done = 1;
        end
        cpu_req_i = 1'b0;
        cpu_we_i  = 1'b0;
        cpu_sel_i = 4'b1111;
        tick();
        checks++;
        if (!done || lat != 5 || overlap || ram[8'h11] !== 32'hAABBCC99) begin
            errors++;
            $display("FAIL rmw: ack=%0d latency=%0d overlap=%0d ram[11]=%h, required 1 5 0 AABBCC99",
                     done, lat, overlap, ram[8'h11]);
        end
    endtask
`else
    task automatic test_sel_ignored;
        int lat;
        bit done;
        ram[8'h14] = 32'h11111111;
        lat = 0; done = 0;
        cpu_req_i  = 1'b1;
        cpu_we_i   = 1'b1;
        cpu_addr_i = 32'h50;
        cpu_data_i = 32'h22222222;
        cpu_sel_i  = 4'b0001;
        for (int i = 0; i < 12 && !done; i++) begin
            tick();
            lat++;
            if (cpu_ack_o) done = 1;
        end
        cpu_req_i = 1'b0;
        cpu_we_i  = 1'b0;
        cpu_sel_i = 4'b1111;
        tick();
        checks++;
        if (!done || lat != 3 || ram[8'h14] !== 32'h22222222) begin
            errors++;
            $display("FAIL sel_ignored: ack=%0d latency=%0d ram[14]=%h, required 1 3 22222222",
                     done, lat, ram[8'h14]);
        end
    endtask
`endif

    initial begin
        rst        = 1'b1;
        cpu_req_i  = 1'b0;
        cpu_we_i   = 1'b0;
        cpu_addr_i = 32'h0;
        cpu_data_i = 32'h0;
        cpu_sel_i  = 4'b1111;
        for (int i = 0; i < 256; i++) ram[i] = 32'h0;
        #2;
        test_reset();
        test_read();
        test_write();
        test_back_to_back();
        test_latched();
`ifdef RAM1_BYTE_WRITE_EN
        test_rmw();
`else
        test_sel_ignored();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
